// File: rtl/pulp_io_uart_rx_deser.sv
// UART receive deserializer: oversampled start/data/parity/stop framing.
// Optional parity support is compiled in with PULP_IO_UART_RX_PARITY_EN.
module pulp_io_uart_rx_deser #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_en_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic [1:0]       cfg_bits_i,
    input  logic             cfg_parity_en_i,
    input  logic             cfg_parity_odd_i,
    input  logic             rx_i,
    output logic [7:0]       data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             err_parity_o,
    output logic             err_frame_o,
    output logic             err_overflow_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef PULP_IO_UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_rxq;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_bits;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_err_frame;
    logic             r_err_ovf;
    logic             w_rx_s;
    logic             w_tick;
    logic [2:0]       w_last;

`ifdef PULP_IO_UART_RX_PARITY_EN
    logic             r_par_en;
    logic             r_par_odd;
    logic             r_perr;
    logic             r_err_par;
    logic             w_par_exp;

    assign w_par_exp    = (^r_shift) ^ r_par_odd;
    assign err_parity_o = r_err_par;
`else
    logic             w_unused_par;

    assign w_unused_par = cfg_parity_en_i ^ cfg_parity_odd_i;
    assign err_parity_o = 1'b0;
`endif

    assign w_rx_s         = r_sync2;
    assign w_tick         = (r_cnt == '0);
    assign w_last         = {1'b0, r_bits} + 3'd4;
    assign data_o         = r_data;
    assign valid_o        = r_valid;
    assign err_frame_o    = r_err_frame;
    assign err_overflow_o = r_err_ovf;
    assign busy_o         = (r_state != S_IDLE);

    // Two-flop synchronizer plus one delay flop for falling-edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rxq   <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
            r_rxq   <= r_sync2;
        end
    end

    // Frame FSM, bit timer, shift register and output holding register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_div       <= '0;
            r_bits      <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_err_frame <= 1'b0;
            r_err_ovf   <= 1'b0;
`ifdef PULP_IO_UART_RX_PARITY_EN
            r_par_en    <= 1'b0;
            r_par_odd   <= 1'b0;
            r_perr      <= 1'b0;
            r_err_par   <= 1'b0;
`endif
        end else begin
            r_err_frame <= 1'b0;
            r_err_ovf   <= 1'b0;
`ifdef PULP_IO_UART_RX_PARITY_EN
            r_err_par   <= 1'b0;
`endif
            if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
            if (!cfg_en_i) begin
                r_state <= S_IDLE;
            end else begin
                if (r_state != S_IDLE) begin
                    r_cnt <= w_tick ? r_div - DIV_W'(1) : r_cnt - DIV_W'(1);
                end
                unique case (r_state)
                    S_IDLE: begin
                        if (r_rxq && !w_rx_s) begin
                            r_state <= S_START;
                            r_cnt   <= (cfg_div_i >> 1) - DIV_W'(1);
                            r_div   <= cfg_div_i;
                            r_bits  <= cfg_bits_i;
                            r_idx   <= '0;
                            r_shift <= '0;
`ifdef PULP_IO_UART_RX_PARITY_EN
                            r_par_en  <= cfg_parity_en_i;
                            r_par_odd <= cfg_parity_odd_i;
                            r_perr    <= 1'b0;
`endif
                        end
                    end
                    S_START: begin
                        if (w_tick) begin
                            r_state <= w_rx_s ? S_IDLE : S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_tick) begin
                            r_shift[r_idx] <= w_rx_s;
                            if (r_idx == w_last) begin
`ifdef PULP_IO_UART_RX_PARITY_EN
                                r_state <= r_par_en ? S_PARITY : S_STOP;
`else
                                r_state <= S_STOP;
`endif
                            end else begin
                                r_idx <= r_idx + 3'd1;
                            end
                        end
                    end
`ifdef PULP_IO_UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (w_tick) begin
                            r_perr  <= (w_rx_s != w_par_exp);
                            r_state <= S_STOP;
                        end
                    end
`endif
                    S_STOP: begin
                        if (w_tick) begin
                            r_state     <= S_IDLE;
                            r_err_frame <= !w_rx_s;
`ifdef PULP_IO_UART_RX_PARITY_EN
                            r_err_par   <= r_perr;
`endif
                            if (!r_valid || ready_i) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_err_ovf <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/pulp_io_uart_rx_deser.md
# pulp_io_uart_rx_deser

Receive-side deserializer for the UART peripheral in the pulp_io subsystem. Sits between the pad-side RX line and the uDMA RX channel. Oversamples the asynchronous serial input, frames start/data/parity/stop bits and presents each received character on a valid/ready stream with per-character error pulses.

## Interface
Parameters:
- `DIV_W`, 16, width of the baud divider (cycles per bit)

Ports:
- `clk_i`  in  1  peripheral clock
- `rst_ni`  in  1  reset, synchronous, active-low
- `cfg_en_i`  in  1  receiver enable
- `cfg_div_i`  in  DIV_W  clock cycles per bit; legal values ≥ 4
- `cfg_bits_i`  in  2  data bits: 0→5, 1→6, 2→7, 3→8
- `cfg_parity_en_i`  in  1  parity bit present
- `cfg_parity_odd_i`  in  1  1 = odd parity, 0 = even parity
- `rx_i`  in  1  asynchronous serial input; idle high
- `data_o`  out  8  received character, right-aligned, unused upper bits 0
- `valid_o`  out  1  `data_o` holds an unconsumed character
- `ready_i`  in  1  consumer accepts `data_o`
- `err_parity_o`  out  1  one-cycle pulse: parity mismatch
- `err_frame_o`  out  1  one-cycle pulse: stop bit sampled 0
- `err_overflow_o`  out  1  one-cycle pulse: character dropped
- `busy_o`  out  1  frame in progress (FSM not IDLE)

## Operation
- `rx_i` passes through a 2-flop synchronizer (reset value 1), giving `rx_s`. One further flop holds `rx_q` for falling-edge detection.
- Configuration (`cfg_div_i`, `cfg_bits_i`, parity fields) is latched on the start edge and held for the whole frame. Changes mid-frame do not affect the current frame.
- Bit counter: a down-counter. A sample fires in the cycle where the count is 0; the counter then reloads `div-1`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when `cfg_en_i`=1 and `rx_q`=1, `rx_s`=0 → START, counter loaded with `div/2 - 1` (floor).
  - START: at sample, `rx_s`=0 → DATA with counter `div-1`; `rx_s`=1 → IDLE (glitch reject, no output, no error).
  - DATA: at each sample, shift `rx_s` in LSB-first; after N bits → PARITY if parity enabled, else STOP.
  - PARITY: at sample, compare `rx_s` against the XOR of the data bits (inverted for odd) → STOP.
  - STOP: at sample → IDLE. The character is committed in the same cycle.
- Commit, i.e. output holding register update:
  - Register empty, or `ready_i`=1 in the same cycle → load the character and keep `valid_o`=1.
  - Otherwise drop the new character, keep the old one, and pulse `err_overflow_o`.
- `err_parity_o` and `err_frame_o` pulse with the commit. The character is still delivered (or dropped on overflow).
- Handshake: transfer occurs when `valid_o`&`ready_i`. `valid_o` is held and `data_o` is stable until transfer. No combinational path from `ready_i` to `valid_o`.
- `cfg_en_i`=0: FSM forced to IDLE next cycle and any in-flight frame is discarded without errors. The holding register and `valid_o` are retained.

## Timing
- Reset: `data_o`=0, `valid_o`=0, all `err_*`=0, `busy_o`=0, FSM IDLE, synchronizer flops =1.
- `rx_i` falling edge → FSM leaves IDLE 3 cycles later (2 sync + edge detect).
- Start sample fires `div/2` cycles after leaving IDLE. Data, parity and stop samples follow at `div`-cycle spacing.
- `valid_o` and error pulses are asserted in the cycle after the stop sample.
- Back-to-back frames: a new falling edge is accepted in the first IDLE cycle after STOP.
- Reset asserted mid-frame: all state returns to reset values on the next clock edge.

## Configuration
- `PULP_IO_UART_RX_PARITY_EN` defined: PARITY state and parity checking are present, and `err_parity_o` is functional.
- Not defined: PARITY state is removed, `cfg_parity_en_i` and `cfg_parity_odd_i` are ignored (frames never carry a parity bit), and `err_parity_o` is tied to 0.

## Test plan
- 8N1, div=16, send 0xA5, `ready_i`=1 → `valid_o` one cycle after the stop sample, `data_o`=0xA5, no errors, `busy_o` low afterward.
- div=16, `rx_i` low for 4 cycles then high → no `valid_o`, no errors, FSM back in IDLE.
- Macro defined, 8E1, send 0x07 with parity bit 0 (correct bit is 1) → `err_parity_o` pulse, `data_o`=0x07.
- 5N1, send 0x1F with stop bit driven 0 → `err_frame_o` pulse, `data_o`=0x1F.
- Send 0x11 then 0x22 with `ready_i`=0 → `err_overflow_o` pulse at the second commit, `data_o` stays 0x11. Raise `ready_i` → `valid_o` drops next cycle.
- Deassert `cfg_en_i` mid-DATA → `busy_o`=0 next cycle, no `valid_o`, no error pulses.
